// File: rtl/quad_pkg.sv
// Shared types and helpers for the quadrature decoder: FSM states,
// the forward Gray-code successor and the startup settling length.
package quad_pkg;

   typedef enum logic {INIT, RUN} state_t;

   // Forward (A leads) successor of a {A,B} pair.
   // The reverse successor is the inverse mapping.
   function automatic logic [1:0] fwd_next(input logic [1:0] ab);
      logic [1:0] nxt;
      case (ab)
         2'b00:   nxt = 2'b10;
         2'b10:   nxt = 2'b11;
         2'b11:   nxt = 2'b01;
         default: nxt = 2'b00;
      endcase
      return nxt;
   endfunction

   // Cycles spent in INIT after reset release: long enough for the
   // synchroniser and filter to settle plus one cycle to load prev.
   function automatic int init_len(input int sync_stages, input int filter_len);
      return sync_stages + filter_len + 1;
   endfunction

endpackage

// File: rtl/quad_decoder_glitch_filter.sv
// One encoder channel: multi-flop synchroniser followed by a stability
// counter that only accepts a new level after it has persisted for
// FILTER_LEN consecutive cycles.
module glitch_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   localparam int CW = $clog2(FILTER_LEN + 1);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic [CW-1:0]          cnt_reg;
   logic                   level_reg;
   logic                   sync_out;

   // Shift the asynchronous input through the synchroniser chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_reg <= '0;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
      end
   end

   assign sync_out = sync_reg[SYNC_STAGES-1];

   // Count consecutive disagreements; adopt the new level on the Nth one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg   <= '0;
         level_reg <= 1'b0;
      end else if (sync_out == level_reg) begin
         cnt_reg <= '0;
      end else if (cnt_reg == CW'(FILTER_LEN - 1)) begin
         level_reg <= sync_out;
         cnt_reg   <= '0;
      end else begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   assign dout = level_reg;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder front end: filters both channels, then decodes the
// Gray-code sequence into a step pulse, a held direction and a sticky
// error for simultaneous changes on both channels.
module quad_decoder
   import quad_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic a_in,
   input  logic b_in,
   input  logic en,
   input  logic err_clr,
   output logic step,
   output logic up_down,
   output logic err
);

   localparam int INIT_LEN = init_len(SYNC_STAGES, FILTER_LEN);
   localparam int IW       = $clog2(INIT_LEN + 1);

   logic [1:0]    raw;
   logic [1:0]    cur;
   logic [1:0]    prev_reg;
   state_t        state_reg, state_next;
   logic [IW-1:0] init_cnt_reg, init_cnt_next;
   logic          step_reg, step_next;
   logic          up_down_reg, up_down_next;
   logic          err_reg, err_next;

   // Bit 1 carries A, bit 0 carries B.
   assign raw = {a_in, b_in};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_chan
         glitch_filter #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILTER_LEN (FILTER_LEN)
         ) u_filter (
            .clk (clk),
            .rst (rst),
            .din (raw[gi]),
            .dout(cur[gi])
         );
      end
   endgenerate

   // State, history and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= INIT;
         init_cnt_reg <= '0;
         prev_reg     <= 2'b00;
         step_reg     <= 1'b0;
         up_down_reg  <= 1'b1;
         err_reg      <= 1'b0;
      end else begin
         state_reg    <= state_next;
         init_cnt_reg <= init_cnt_next;
         prev_reg     <= cur;
         step_reg     <= step_next;
         up_down_reg  <= up_down_next;
         err_reg      <= err_next;
      end
   end

   // Next-state and decode: classify cur against prev once settled.
   always_comb begin
      state_next    = state_reg;
      init_cnt_next = init_cnt_reg;
      step_next     = 1'b0;
      up_down_next  = up_down_reg;
      err_next      = err_reg & ~err_clr;
      case (state_reg)
         INIT: begin
            if (init_cnt_reg == IW'(INIT_LEN - 1)) begin
               state_next = RUN;
            end else begin
               init_cnt_next = init_cnt_reg + 1'b1;
            end
         end
         RUN: begin
            if (cur != prev_reg) begin
               if (cur == fwd_next(prev_reg)) begin
                  step_next    = en;
                  up_down_next = 1'b1;
               end else if (prev_reg == fwd_next(cur)) begin
                  step_next    = en;
                  up_down_next = 1'b0;
               end else begin
                  // Both channels moved at once: direction is unknowable.
                  err_next = 1'b1;
               end
            end
         end
         default: state_next = INIT;
      endcase
   end

   assign step    = step_reg;
   assign up_down = up_down_reg;
   assign err     = err_reg;

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: reference model built from sampled-input
// history (a level is adopted once S..S+F-1 samples back all disagree
// with it), table-driven segments, randomized segments and async reset.
module tb_quad_decoder;

   localparam int S        = 2;
   localparam int F        = 4;
   localparam int INIT_LEN = S + F + 1;
   localparam int MAXN     = 8192;

   logic clk = 1'b0;
   logic rst, a_in, b_in, en, err_clr;
   logic step, up_down, err;

   quad_decoder #(.SYNC_STAGES(S), .FILTER_LEN(F)) dut (
      .clk    (clk),
      .rst    (rst),
      .a_in   (a_in),
      .b_in   (b_in),
      .en     (en),
      .err_clr(err_clr),
      .step   (step),
      .up_down(up_down),
      .err    (err)
   );

   always #5 clk = ~clk;

   int   total = 0;
   int   bad   = 0;
   int   n;
   logic sa [0:MAXN];
   logic sb [0:MAXN];
   logic fa [0:MAXN];
   logic fb [0:MAXN];
   logic m_step, m_up, m_err;

   typedef struct {
      logic a, b, en, clr;
      int   hold;
      int   steps;
      int   first;
      logic up;
      logic err;
   } vec_t;

   vec_t tbl [19];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at edge %0d: got %0d expected %0d", name, n, act, exp);
      end
   endtask

   function automatic logic smp(input int ch, input int idx);
      if (idx < 1) return 1'b0;
      return (ch == 0) ? sa[idx] : sb[idx];
   endfunction

   function automatic logic flt(input int ch, input int idx);
      if (idx < 1) return 1'b0;
      return (ch == 0) ? fa[idx] : fb[idx];
   endfunction

   // Filtered level after edge k: flips only if the last F samples that
   // have cleared the synchroniser all disagree with the old level.
   function automatic logic filt_at(input int ch, input int k);
      logic old;
      old = flt(ch, k - 1);
      for (int j = k - S - F + 1; j <= k - S; j++)
         if (smp(ch, j) == old) return old;
      return ~old;
   endfunction

   // Position on the forward cycle 00,10,11,01.
   function automatic int pos(input logic [1:0] ab);
      case (ab)
         2'b00:   return 0;
         2'b10:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   task automatic model_reset();
      n      = 0;
      m_step = 1'b0;
      m_up   = 1'b1;
      m_err  = 1'b0;
   endtask

   // One clock: sample inputs, advance the model, compare outputs.
   task automatic tick();
      logic [1:0] cur, prv;
      logic       legal, fwd, set;
      @(posedge clk);
      n++;
      if (n >= MAXN) begin
         $display("FAIL model_overflow at edge %0d: got %0d expected %0d", n, n, MAXN - 1);
         $fatal(1, "history overflow");
      end
      sa[n] = a_in;
      sb[n] = b_in;
      fa[n] = filt_at(0, n);
      fb[n] = filt_at(1, n);
      cur   = {flt(0, n - 1), flt(1, n - 1)};
      prv   = {flt(0, n - 2), flt(1, n - 2)};
      legal = 1'b0;
      fwd   = 1'b0;
      set   = 1'b0;
      if (n > INIT_LEN && cur != prv) begin
         if ((cur ^ prv) == 2'b11) set = 1'b1;
         else begin
            legal = 1'b1;
            fwd   = (((pos(cur) - pos(prv) + 4) % 4) == 1);
         end
      end
      m_step = legal & en;
      if (legal) m_up = fwd;
      m_err = set | (m_err & ~err_clr);
      #1;
      check("step", step, m_step);
      check("up_down", up_down, m_up);
      check("err", err, m_err);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("rst_step", step, 0);
      check("rst_up_down", up_down, 1);
      check("rst_err", err, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      int cnt, first, hold;
      a_in = 1'b0; b_in = 1'b0; en = 1'b1; err_clr = 1'b0;
      model_reset();

      //            a     b     en    clr   hold st fi up    err
      tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 10, 1, 7, 1'b1, 1'b0};
      tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 10, 1, 7, 1'b1, 1'b0};
      tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 10, 1, 7, 1'b1, 1'b0};
      tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 10, 1, 7, 1'b1, 1'b0};
      tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 10, 1, 7, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 10, 1, 7, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 10, 1, 7, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 10, 1, 7, 1'b0, 1'b0};
      tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0,  3, 0, 0, 1'b0, 1'b0};
      tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 10, 0, 0, 1'b0, 1'b0};
      tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0,  4, 0, 0, 1'b0, 1'b0};
      tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 12, 2, 3, 1'b0, 1'b0};
      tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 10, 0, 0, 1'b0, 1'b1};
      tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0,  6, 0, 0, 1'b0, 1'b1};
      tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b1,  1, 0, 0, 1'b0, 1'b1};
      tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b0,  3, 0, 0, 1'b0, 1'b1};
      tbl[16] = '{1'b0, 1'b0, 1'b1, 1'b1,  1, 0, 0, 1'b0, 1'b0};
      tbl[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 10, 0, 0, 1'b1, 1'b0};
      tbl[18] = '{1'b1, 1'b0, 1'b1, 1'b0,  5, 0, 0, 1'b1, 1'b0};

      do_reset();

      // Idle through INIT and beyond.
      repeat (20) tick();

      // Table-driven segments.
      for (int i = 0; i < 19; i++) begin
         a_in    = tbl[i].a;
         b_in    = tbl[i].b;
         en      = tbl[i].en;
         err_clr = tbl[i].clr;
         cnt     = 0;
         first   = 0;
         for (int k = 1; k <= tbl[i].hold; k++) begin
            tick();
            if (step) begin
               cnt++;
               if (first == 0) first = k;
            end
         end
         check($sformatf("vec%0d_steps", i), cnt, tbl[i].steps);
         check($sformatf("vec%0d_first", i), first, tbl[i].first);
         check($sformatf("vec%0d_up", i), up_down, tbl[i].up);
         check($sformatf("vec%0d_err", i), err, tbl[i].err);
      end
      err_clr = 1'b0;
      en      = 1'b1;

      // Randomized segments against the model.
      for (int s = 0; s < 250; s++) begin
         {a_in, b_in} = 2'($urandom_range(0, 3));
         en   = ($urandom_range(0, 3) != 0);
         hold = $urandom_range(1, 12);
         for (int k = 0; k < hold; k++) begin
            err_clr = ($urandom_range(0, 7) == 0);
            tick();
         end
      end
      err_clr = 1'b0;
      en      = 1'b1;

      // Build up step=1, up_down=0, err=1, then reset mid-cycle.
      do_reset();
      a_in = 1'b0; b_in = 1'b0; repeat (10) tick();
      a_in = 1'b0; b_in = 1'b1; repeat (10) tick();
      a_in = 1'b1; b_in = 1'b0; repeat (10) tick();
      a_in = 1'b0; b_in = 1'b0; repeat (7) tick();
      check("pre_rst_step", step, 1);
      check("pre_rst_up_down", up_down, 0);
      check("pre_rst_err", err, 1);
      #3;
      do_reset();

      // A transition settling inside INIT must not produce a step.
      a_in = 1'b1; b_in = 1'b0;
      cnt = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (step) cnt++;
      end
      check("init_swallow_steps", cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
